// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default depth,
// stream-format constants and the loader state encoding.
// Optional feature macro: IM_LOADER_CHECKSUM_EN (adds the CSUM state).
package im_loader_pkg;

    localparam int unsigned IM_DEPTH_DEF   = 1024;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_SHIFT     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_FINISH = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte stream in, instruction-memory write port and status out.
// The slave modport is the loader's view; master is the driving environment.
interface im_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_hold, done, error
    );

endinterface

// File: rtl/im_loader_word_assemble.sv
// Collects bytes MSB first into 32-bit words. word_vld_o pulses in the same
// cycle the fourth byte is presented, with the completed word on word_o.
module im_loader_word_assemble
    import im_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    assign word_vld_o = byte_vld_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o     = {shift_q, byte_i};

    // Byte counter and shift register; a clear drops any partial word.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_vld_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    // State registers for the assembler.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: reads a 16-bit word count, then streams
// big-endian words into instruction memory and releases the core when done.
// Optional feature macro: IM_LOADER_CHECKSUM_EN (XOR checksum byte after data).
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned IM_DEPTH  = IM_DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    im_loader_if.slave  lif
);

    state_t      state_q, state_d;
    logic        ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] widx_q;

    logic        xfer;
    logic        data_xfer;
    logic [15:0] len_w;
    logic        word_vld;
    logic [31:0] word;

    assign xfer      = lif.in_valid && ready_q;
    assign data_xfer = xfer && (state_q == ST_DATA);
    assign len_w     = {len_hi_q, lif.in_data};

    im_loader_word_assemble u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (state_q != ST_DATA),
        .byte_vld_i (data_xfer),
        .byte_i     (lif.in_data),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR of data bytes; restarted when a new length is accepted.
    always_comb begin
        csum_d = csum_q;
        if (xfer && state_q == ST_LEN_LO) csum_d = '0;
        else if (data_xfer)               csum_d = csum_q ^ lif.in_data;
    end

    // Checksum register.
    always_ff @(posedge clock) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end
`endif

    // Next-state logic of the loader FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_w == 16'd0)                 state_d = ST_FINISH;
                    else if (32'(len_w) > IM_DEPTH)     state_d = ST_ERR;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA: if (word_vld && widx_q == len_q - 16'd1) state_d = ST_FINISH;
`ifdef IM_LOADER_CHECKSUM_EN
            ST_FINISH: state_d = ST_CSUM;
            ST_CSUM: if (xfer) state_d = (lif.in_data == csum_q) ? ST_DONE : ST_ERR;
`else
            ST_FINISH: state_d = ST_DONE;
`endif
            ST_DONE:   state_d = ST_DONE;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_ERR;
        endcase
    end

    // State, handshake, length/index counters and the registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LEN_HI;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= BASE_ADDR;
            wdata_q  <= '0;
            len_hi_q <= '0;
            len_q    <= '0;
            widx_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= accepts_bytes(state_d);
            we_q    <= word_vld;
            if (xfer && state_q == ST_LEN_HI) len_hi_q <= lif.in_data;
            if (xfer && state_q == ST_LEN_LO) begin
                len_q  <= len_w;
                widx_q <= '0;
            end else if (word_vld) begin
                widx_q <= widx_q + 16'd1;
            end
            if (word_vld) begin
                addr_q  <= BASE_ADDR + ({16'd0, widx_q} << WORD_SHIFT);
                wdata_q <= word;
            end
        end
    end

    assign lif.in_ready = ready_q;
    assign lif.im_we    = we_q;
    assign lif.im_addr  = addr_q;
    assign lif.im_wdata = wdata_q;
    assign lif.done     = (state_q == ST_DONE);
    assign lif.error    = (state_q == ST_ERR);
    assign lif.cpu_hold = (state_q != ST_DONE);

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: builds images from a byte-level model (expected
// writes, outcome and latency) and compares them to the write port.
// Honors IM_LOADER_CHECKSUM_EN when compiled with it.
module tb_im_loader;

    localparam int unsigned IM_DEPTH  = 16;
    localparam logic [31:0] BASE_ADDR = 32'h0000_1000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    im_loader_if bus ();

    im_loader #(.IM_DEPTH(IM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clock (clock),
        .reset (reset),
        .lif   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [7:0]  t1 [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr, data) pair.
    always @(negedge clock) begin
        if (!reset && bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_addr", bus.im_addr, mon_e[63:32]);
                chk("we_data", bus.im_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic apply_reset(input bit check_vals);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (check_vals) begin
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
            chk("rst_im_we",    32'(bus.im_we),    32'd0);
            chk("rst_im_addr",  bus.im_addr,       BASE_ADDR);
            chk("rst_im_wdata", bus.im_wdata,      32'd0);
            chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
            chk("rst_done",     32'(bus.done),     32'd0);
            chk("rst_error",    32'(bus.error),    32'd0);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    endtask

    // gmode: 0 back-to-back, 1 idle cycle before every byte, 2 random idles.
    task automatic send_byte(input logic [7:0] b, input int gmode, input bit chk_rdy);
        int w;
        if (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) == 0)) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        if (chk_rdy) chk("ready_in_data", 32'(bus.in_ready), 32'd1);
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_image(input int n, input bit use_t1, input int gmode, input bit bad_cs);
        logic [7:0]  s[$];
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] nh;
        bit          exp_err;
        int          ndata, lat, k;
        nh = 16'(n);
        s.push_back(nh[15:8]);
        s.push_back(nh[7:0]);
        cs = 8'h00;
        w  = 32'h0;
        exp_err = (n > int'(IM_DEPTH));
        ndata   = exp_err ? 0 : n;
        for (int i = 0; i < ndata; i++) begin
            for (int j = 0; j < 4; j++) begin
                b  = use_t1 ? t1[i*4+j] : 8'($urandom);
                w  = {w[23:0], b};
                cs = cs ^ b;
                s.push_back(b);
            end
            exp_q.push_back({BASE_ADDR + 32'(4 * i), w});
        end
        lat = exp_err ? 0 : 1;
`ifdef IM_LOADER_CHECKSUM_EN
        if (!exp_err) begin
            s.push_back(bad_cs ? (cs ^ 8'h01) : cs);
            lat = 0;
            exp_err = bad_cs;
        end
`endif
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], gmode, (i >= 2 && i < 2 + 4 * ndata));
        k = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("end_latency", 32'(k), 32'(lat));
        chk("done",     32'(bus.done),     exp_err ? 32'd0 : 32'd1);
        chk("error",    32'(bus.error),    exp_err ? 32'd1 : 32'd0);
        chk("cpu_hold", 32'(bus.cpu_hold), exp_err ? 32'd1 : 32'd0);
        chk("ready_end", 32'(bus.in_ready), 32'd0);
        // Bytes offered in a terminal state must be ignored.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("ready_terminal", 32'(bus.in_ready), 32'd0);
        chk("done_sticky",  32'(bus.done),  exp_err ? 32'd0 : 32'd1);
        chk("error_sticky", 32'(bus.error), exp_err ? 32'd1 : 32'd0);
        chk("writes_left",  32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        t1[0] = 8'h20; t1[1] = 8'h08; t1[2] = 8'h00; t1[3] = 8'h05;
        t1[4] = 8'h01; t1[5] = 8'h09; t1[6] = 8'h50; t1[7] = 8'h20;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        apply_reset(1'b1);
        run_image(2, 1'b1, 0, 1'b0);          // known two-word program, back-to-back
        apply_reset(1'b0);
        run_image(2, 1'b1, 1, 1'b0);          // same program, valid toggling
        apply_reset(1'b0);
        run_image(0, 1'b0, 0, 1'b0);          // empty image
        apply_reset(1'b0);
        run_image(1025, 1'b0, 0, 1'b0);       // header 04 01, too long
        apply_reset(1'b0);
        run_image(int'(IM_DEPTH) + 1, 1'b0, 2, 1'b0);
        apply_reset(1'b0);
        run_image(int'(IM_DEPTH), 1'b0, 2, 1'b0);
        apply_reset(1'b0);

        // Reset in the middle of word 1: only word 0 of the aborted image lands.
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        exp_q.push_back({BASE_ADDR, 32'hDEAD_BEEF});
        send_byte(8'hDE, 0, 1'b1);
        send_byte(8'hAD, 0, 1'b1);
        send_byte(8'hBE, 0, 1'b1);
        send_byte(8'hEF, 0, 1'b1);
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h33, 0, 1'b1);
        apply_reset(1'b0);
        run_image(2, 1'b1, 0, 1'b0);
        apply_reset(1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
        run_image(2, 1'b1, 0, 1'b1);          // wrong checksum byte
        apply_reset(1'b0);
`endif
        for (int r = 0; r < 8; r++) begin
            run_image($urandom_range(1, 8), 1'b0, 2, 1'($urandom_range(0, 1)));
            apply_reset(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
